// File: rtl/multicrack_sched.sv
// multicrack_sched: launches N crack cores, arbitrates their ciphertext reads, and reports the first found key
module multicrack_sched #(
  parameter int N_CORES = 4,
  parameter int KEY_W   = 24,
  parameter int CT_AW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic                     rdy,
  output logic [KEY_W-1:0]         key,
  output logic                     key_valid,
  output logic [CT_AW-1:0]         ct_addr,
  input  logic [7:0]               ct_rddata,
  output logic [N_CORES-1:0]       core_start,
  output logic [N_CORES*KEY_W-1:0] core_key_base,
  output logic                     core_abort,
  input  logic [N_CORES-1:0]       core_done,
  input  logic [N_CORES-1:0]       core_found,
  input  logic [N_CORES*KEY_W-1:0] core_key,
  input  logic [N_CORES-1:0]       core_ct_req,
  input  logic [N_CORES*CT_AW-1:0] core_ct_addr,
  output logic [N_CORES-1:0]       core_ct_gnt,
  output logic [N_CORES-1:0]       core_ct_vld
);
  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ABORT, REPORT} state_t;
  state_t state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic key_valid_q, key_valid_d;
  logic [CT_AW-1:0] addr_q;
  logic [PW-1:0] ptr_q, ptr_d, gnt_idx, hit_idx, idx;
  logic [N_CORES-1:0] vld_q, gnt, hit;
  logic gnt_any, hit_any;
  logic unused_rddata;
  assign unused_rddata = ^ct_rddata;
  for (genvar i = 0; i < N_CORES; i++) begin : g_base
    assign core_key_base[i*KEY_W +: KEY_W] = KEY_W'(i);
  end
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int j = N_CORES-1; j >= 0; j--) begin
      idx = ptr_q + PW'(j);
      if (core_ct_req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_any = gnt_any && (state_q == RUN);
  end
  always_comb begin
    hit = core_done & core_found;
    hit_any = |hit;
    hit_idx = '0;
    for (int j = N_CORES-1; j >= 0; j--) begin
      if (hit[j]) hit_idx = PW'(j);
    end
  end
  assign gnt = gnt_any ? N_CORES'(1) << gnt_idx : '0;
  assign ct_addr = gnt_any ? core_ct_addr[int'(gnt_idx)*CT_AW +: CT_AW] : addr_q;
  assign ptr_d = gnt_any ? gnt_idx + PW'(1) : ptr_q;
  assign rdy = state_q == IDLE;
  assign core_start = {N_CORES{state_q == LAUNCH}};
  assign core_abort = state_q == ABORT;
  assign core_ct_gnt = gnt;
  assign core_ct_vld = vld_q;
  assign key = key_q;
  assign key_valid = key_valid_q;
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    key_valid_d = key_valid_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LAUNCH;
          key_d = '0;
          key_valid_d = 1'b0;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (hit_any) begin
          state_d = ABORT;
          key_d = core_key[int'(hit_idx)*KEY_W +: KEY_W];
          key_valid_d = 1'b1;
        end else if (&core_done) begin
          state_d = REPORT;
        end
      end
      ABORT: state_d = REPORT;
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q <= '0;
      key_valid_q <= 1'b0;
      addr_q <= '0;
      ptr_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      key_valid_q <= key_valid_d;
      addr_q <= ct_addr;
      ptr_q <= ptr_d;
      vld_q <= gnt;
    end
  end
endmodule

// File: tb/tb_multicrack_sched.sv
// tb_multicrack_sched: randomized and directed checks of multicrack_sched against a behavioural model
module tb_multicrack_sched;
  localparam int N = 4;
  localparam int KW = 24;
  localparam int AW = 8;
  localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_RUN = 2, PH_ABORT = 3, PH_REPORT = 4;
  logic clk = 1'b0;
  logic rst, en, rdy, key_valid, core_abort;
  logic [KW-1:0] key;
  logic [AW-1:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [N-1:0] core_start, core_done, core_found, core_ct_req, core_ct_gnt, core_ct_vld;
  logic [N*KW-1:0] core_key_base, core_key;
  logic [N*AW-1:0] core_ct_addr;
  logic [7:0] ram [256];
  int vectors = 0;
  int miscompares = 0;
  int m_phase, m_ptr, m_vld, m_k, m_hit;
  logic [KW-1:0] m_key;
  logic m_kv, m_init = 1'b0;
  logic [AW-1:0] m_addr, m_vld_addr;
  logic [N-1:0] exp_gnt, exp_vld;
  logic [AW-1:0] exp_addr;
  logic [N*KW-1:0] base_lit;
  always #5 clk = ~clk;
  multicrack_sched #(.N_CORES(N), .KEY_W(KW), .CT_AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata), .core_start(core_start),
    .core_key_base(core_key_base), .core_abort(core_abort), .core_done(core_done),
    .core_found(core_found), .core_key(core_key), .core_ct_req(core_ct_req),
    .core_ct_addr(core_ct_addr), .core_ct_gnt(core_ct_gnt), .core_ct_vld(core_ct_vld)
  );
  always @(posedge clk) ct_rddata <= ram[ct_addr];
  function automatic int rr_pick(int ptr, logic [N-1:0] req);
    for (int j = 0; j < N; j++) if (req[(ptr + j) % N]) return (ptr + j) % N;
    return -1;
  endfunction
  function automatic int lowest(logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction
  always_comb begin
    m_k = (m_phase == PH_RUN) ? rr_pick(m_ptr, core_ct_req) : -1;
    m_hit = lowest(core_done & core_found);
    exp_gnt = (m_k >= 0) ? N'(1) << m_k : '0;
    exp_addr = (m_k >= 0) ? core_ct_addr[m_k*AW +: AW] : m_addr;
    exp_vld = (m_vld >= 0) ? N'(1) << m_vld : '0;
  end
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= PH_IDLE;
      m_key <= '0;
      m_kv <= 1'b0;
      m_addr <= '0;
      m_ptr <= 0;
      m_vld <= -1;
      m_init <= 1'b1;
    end else begin
      m_vld <= m_k;
      if (m_k >= 0) begin
        m_vld_addr <= core_ct_addr[m_k*AW +: AW];
        m_addr <= core_ct_addr[m_k*AW +: AW];
        m_ptr <= (m_k + 1) % N;
      end
      case (m_phase)
        PH_IDLE: if (en) begin
          m_phase <= PH_LAUNCH;
          m_key <= '0;
          m_kv <= 1'b0;
        end
        PH_LAUNCH: m_phase <= PH_RUN;
        PH_RUN: if (m_hit >= 0) begin
          m_phase <= PH_ABORT;
          m_key <= core_key[m_hit*KW +: KW];
          m_kv <= 1'b1;
        end else if (&core_done) m_phase <= PH_REPORT;
        PH_ABORT: m_phase <= PH_REPORT;
        default: m_phase <= PH_IDLE;
      endcase
    end
  end
  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m_init) begin
      check("rdy", rdy, m_phase == PH_IDLE);
      check("core_start", core_start, (m_phase == PH_LAUNCH) ? {N{1'b1}} : '0);
      check("core_abort", core_abort, m_phase == PH_ABORT);
      check("core_key_base", core_key_base, base_lit);
      check("core_ct_gnt", core_ct_gnt, exp_gnt);
      check("ct_addr", ct_addr, exp_addr);
      check("core_ct_vld", core_ct_vld, exp_vld);
      check("key", key, m_key);
      check("key_valid", key_valid, m_kv);
      if (m_vld >= 0) check("ct_rddata", ct_rddata, ram[m_vld_addr]);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < N; i++) base_lit[i*KW +: KW] = KW'(i);
    rst = 1'b1; en = 1'b0; core_done = '0; core_found = '0; core_key = '0;
    core_ct_req = '0; core_ct_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset rdy", rdy, 1'b1);
    check("reset key_valid", key_valid, 1'b0);
    check("reset key", key, 24'h0);
    check("reset gnt", core_ct_gnt, 4'b0000);
    en = 1'b1;
    tick();
    en = 1'b0;
    core_ct_req = 4'b1111;
    core_ct_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    check("launch rdy", rdy, 1'b0);
    check("launch start", core_start, 4'b1111);
    check("launch base", core_key_base, {24'd3, 24'd2, 24'd1, 24'd0});
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr gnt", core_ct_gnt, 4'b0001 << (i % 4));
      check("rr addr", ct_addr, 8'h10 + 8'(i % 4));
      tick();
    end
    core_ct_req = '0;
    core_done = 4'b1010;
    core_found = 4'b1010;
    core_key = {24'h000013, 24'h0, 24'h000011, 24'h0};
    tick();
    core_done = 4'b1111;
    core_found = 4'b1111;
    core_key = {24'h0000a3, 24'h0000a2, 24'h0000a1, 24'h0000a0};
    @(negedge clk);
    check("tie key", key, 24'h000011);
    check("tie key_valid", key_valid, 1'b1);
    check("tie abort", core_abort, 1'b1);
    tick();
    @(negedge clk);
    check("abort one cycle", core_abort, 1'b0);
    check("abort key hold", key, 24'h000011);
    tick();
    @(negedge clk);
    check("tie rdy back", rdy, 1'b1);
    core_done = '0;
    core_found = '0;
    en = 1'b1;
    tick();
    en = 1'b0;
    @(negedge clk);
    check("relaunch clears key_valid", key_valid, 1'b0);
    tick();
    core_done = 4'b1111;
    tick();
    @(negedge clk);
    check("nf key_valid", key_valid, 1'b0);
    check("nf key", key, 24'h0);
    check("nf abort", core_abort, 1'b0);
    tick();
    @(negedge clk);
    check("nf rdy back", rdy, 1'b1);
    core_done = '0;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    @(negedge clk);
    check("busy en ignored", core_start, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrun rst rdy", rdy, 1'b1);
    check("midrun rst abort", core_abort, 1'b0);
    check("midrun rst ct_addr", ct_addr, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("no queued launch", core_start, 4'b0000);
    end
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 250) == 0;
      en = ($urandom % 3) == 0;
      core_ct_req = N'($urandom);
      core_ct_addr = N*AW'($urandom);
      core_done = (($urandom % 6) == 0) ? {N{1'b1}} : N'($urandom & $urandom);
      core_found = (($urandom % 5) == 0) ? N'($urandom) : '0;
      core_key = {$urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0; en = 1'b0; core_ct_req = '0; core_done = '0; core_found = '0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
